// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: sub-word loads/stores over a synchronous-read word RAM, with
// debug word-read arbitration. Optional zero-extending loads behind MEM_UNSIGNED_LOAD_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_type,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
`ifdef MEM_UNSIGNED_LOAD_EN
  input  logic              i_unsigned,
`endif
  output logic [31:0]       o_rdata,
  output logic              o_done,
  output logic              o_misaligned,
  output logic              o_stall,
  input  logic              i_dbg_req,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic              o_dbg_ack,
  output logic [31:0]       o_dbg_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    StIdle, StRd, StWait, StWr, StDone, StDrd, StDwait, StDack
  } state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [1:0]        type_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] widx_q;
  logic [31:0]       wdata_q;
  logic              uns_q;
  logic              mis_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [31:0]       rdata_q;
  logic [31:0]       dbg_rdata_q;

  logic        uns_in;
  logic        illegal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_addr;

`ifdef MEM_UNSIGNED_LOAD_EN
  assign uns_in = i_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign unused_addr = ^i_addr[31:ADDR_W+2];

  always_comb begin
    illegal = 1'b1;
    case (i_type)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = i_addr[0];
      3'b011:  illegal = |i_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_req) begin
          if (illegal)                         state_d = StDone;
          else if (i_we && i_type == 3'b011)   state_d = StWr;
          else                                 state_d = StRd;
        end else if (i_dbg_req) begin
          state_d = StDrd;
        end
      end
      StRd:    state_d = StWait;
      StWait:  state_d = we_q ? StWr : StDone;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      StDrd:   state_d = StDwait;
      StDwait: state_d = StDack;
      StDack:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Lane extraction for loads and lane merge for read-modify-write stores.
  always_comb begin
    byte_sel = i_mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = i_mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_val = i_mem_rdata;
    merged   = i_mem_rdata;
    case (type_q)
      2'b00: begin
        load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      lane_q      <= 2'b00;
      widx_q      <= '0;
      wdata_q     <= '0;
      uns_q       <= 1'b0;
      mis_q       <= 1'b0;
      dbg_addr_q  <= '0;
      rdata_q     <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_req) begin
            we_q    <= i_we;
            type_q  <= i_type[1:0];
            lane_q  <= i_addr[1:0];
            widx_q  <= i_addr[ADDR_W+1:2];
            wdata_q <= i_wdata;
            uns_q   <= uns_in;
            mis_q   <= illegal;
            if (illegal) rdata_q <= '0;
          end else if (i_dbg_req) begin
            dbg_addr_q <= i_dbg_addr;
          end
        end
        StWait: begin
          if (we_q) wdata_q <= merged;
          else      rdata_q <= load_val;
        end
        StDwait: dbg_rdata_q <= i_mem_rdata;
        default: ;
      endcase
    end
  end

  // RAM control decodes from state only, so reset drops it in the same instant.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state_q)
      StRd: begin
        o_mem_en   = 1'b1;
        o_mem_addr = widx_q;
      end
      StWr: begin
        o_mem_en    = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = widx_q;
        o_mem_wdata = wdata_q;
      end
      StDrd: begin
        o_mem_en   = 1'b1;
        o_mem_addr = dbg_addr_q;
      end
      default: ;
    endcase
  end

  assign o_rdata      = rdata_q;
  assign o_done       = (state_q == StDone);
  assign o_misaligned = (state_q == StDone) & mis_q;
  assign o_stall      = i_req & (state_q != StDone);
  assign o_dbg_ack    = (state_q == StDack);
  assign o_dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of pipeline accesses against a RAM model,
// plus hand-written debug-arbitration and reset-during-access sequences.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 10;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_req, i_we;
  logic [2:0]        i_type;
  logic [31:0]       i_addr, i_wdata;
`ifdef MEM_UNSIGNED_LOAD_EN
  logic              i_unsigned;
`endif
  logic [31:0]       o_rdata;
  logic              o_done, o_misaligned, o_stall;
  logic              i_dbg_req;
  logic [ADDR_W-1:0] i_dbg_addr;
  logic              o_dbg_ack;
  logic [31:0]       o_dbg_rdata;
  logic              o_mem_en, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_type      (i_type),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
`ifdef MEM_UNSIGNED_LOAD_EN
    .i_unsigned  (i_unsigned),
`endif
    .o_rdata     (o_rdata),
    .o_done      (o_done),
    .o_misaligned(o_misaligned),
    .o_stall     (o_stall),
    .i_dbg_req   (i_dbg_req),
    .i_dbg_addr  (i_dbg_addr),
    .o_dbg_ack   (o_dbg_ack),
    .o_dbg_rdata (o_dbg_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read RAM model with access counters.
  logic [31:0] ram [1 << ADDR_W];
  int nrd = 0;
  int nwr = 0;
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        ram[o_mem_addr] <= o_mem_wdata;
        nwr <= nwr + 1;
      end else begin
        i_mem_rdata <= ram[o_mem_addr];
        nrd <= nrd + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uns;
    int          lat;
    logic        mis;
    int          rds;
    int          wrs;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        chk_ram;
    int          widx;
    logic [31:0] wval;
  } vec_t;

  vec_t vq[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic uns);
    i_req   = 1'b1;
    i_we    = we;
    i_type  = typ;
    i_addr  = addr;
    i_wdata = wdata;
`ifdef MEM_UNSIGNED_LOAD_EN
    i_unsigned = uns;
`else
    if (uns) i_wdata = wdata;
`endif
  endtask

  task automatic run(input vec_t v);
    int lat, r0, w0;
    logic mis;
    logic [31:0] rd;
    lat = 0;
    mis = 1'b0;
    rd  = '0;
    @(posedge i_clk);
    @(negedge i_clk);
    r0 = nrd;
    w0 = nwr;
    drive_req(v.we, v.typ, v.addr, v.wdata, v.uns);
    #1 check({v.name, " stall"}, 32'(o_stall), 32'd1);
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        lat = n;
        mis = o_misaligned;
        rd  = o_rdata;
      end
    end
    i_req = 1'b0;
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " misaligned"}, 32'(mis), 32'(v.mis));
    check({v.name, " ram reads"}, 32'(nrd - r0), 32'(v.rds));
    check({v.name, " ram writes"}, 32'(nwr - w0), 32'(v.wrs));
    if (v.chk_rd) check({v.name, " rdata"}, rd, v.rdata);
    if (v.chk_ram) check({v.name, " ram word"}, ram[v.widx], v.wval);
  endtask

  initial begin
    logic [31:0] exp_lbu;
    int lat, dl, w0;
    logic early;
    logic [31:0] rd, drd;

`ifdef MEM_UNSIGNED_LOAD_EN
    exp_lbu = 32'h000000AB;
`else
    exp_lbu = 32'hFFFFFFAB;
`endif
    //           name       we    typ     addr   wdata          uns lat mis rd wr chk rdata    ram idx value
    vq.push_back('{"sb11",  1'b1, 3'b000, 32'h11, 32'h000000AB, 1'b0, 4, 1'b0, 1, 1, 1'b0, 32'h0, 1'b1, 4, 32'h1122AB44});
    vq.push_back('{"lb11",  1'b0, 3'b000, 32'h11, 32'h0,        1'b0, 3, 1'b0, 1, 0, 1'b1, 32'hFFFFFFAB, 1'b0, 0, 32'h0});
    vq.push_back('{"lh12",  1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 3, 1'b0, 1, 0, 1'b1, 32'h00001122, 1'b0, 0, 32'h0});
    vq.push_back('{"lbu11", 1'b0, 3'b000, 32'h11, 32'h0,        1'b1, 3, 1'b0, 1, 0, 1'b1, exp_lbu,      1'b0, 0, 32'h0});
    vq.push_back('{"sw20",  1'b1, 3'b011, 32'h20, 32'hDEADBEEF, 1'b0, 2, 1'b0, 0, 1, 1'b0, 32'h0, 1'b1, 8, 32'hDEADBEEF});
    vq.push_back('{"lw22",  1'b0, 3'b011, 32'h22, 32'h0,        1'b0, 1, 1'b1, 0, 0, 1'b1, 32'h0, 1'b0, 0, 32'h0});
    vq.push_back('{"typ010",1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 1, 1'b1, 0, 0, 1'b1, 32'h0, 1'b0, 0, 32'h0});
    vq.push_back('{"lw20",  1'b0, 3'b011, 32'h20, 32'h0,        1'b0, 3, 1'b0, 1, 0, 1'b1, 32'hDEADBEEF, 1'b0, 0, 32'h0});
    vq.push_back('{"sh22",  1'b1, 3'b001, 32'h22, 32'h00005566, 1'b0, 4, 1'b0, 1, 1, 1'b0, 32'h0, 1'b1, 8, 32'h5566BEEF});
    vq.push_back('{"lh20",  1'b0, 3'b001, 32'h20, 32'h0,        1'b0, 3, 1'b0, 1, 0, 1'b1, 32'hFFFFBEEF, 1'b0, 0, 32'h0});
    vq.push_back('{"lh21",  1'b0, 3'b001, 32'h21, 32'h0,        1'b0, 1, 1'b1, 0, 0, 1'b1, 32'h0, 1'b0, 0, 32'h0});
    vq.push_back('{"sb23",  1'b1, 3'b000, 32'h23, 32'h12345677, 1'b0, 4, 1'b0, 1, 1, 1'b0, 32'h0, 1'b1, 8, 32'h7766BEEF});
    vq.push_back('{"sw26",  1'b1, 3'b011, 32'h26, 32'hCAFEF00D, 1'b0, 1, 1'b1, 0, 0, 1'b1, 32'h0, 1'b1, 8, 32'h7766BEEF});
    vq.push_back('{"lb13",  1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 3, 1'b0, 1, 0, 1'b1, 32'h00000011, 1'b0, 0, 32'h0});

    ram[4] = 32'h11223344;
    ram[8] = 32'h0;
    i_mem_rdata = '0;
    i_reset_n = 1'b0;
    i_req = 1'b0; i_we = 1'b0; i_type = 3'b000; i_addr = '0; i_wdata = '0;
`ifdef MEM_UNSIGNED_LOAD_EN
    i_unsigned = 1'b0;
`endif
    i_dbg_req = 1'b0; i_dbg_addr = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset o_done", 32'(o_done), 32'd0);
    check("reset o_rdata", o_rdata, 32'd0);
    check("reset o_misaligned", 32'(o_misaligned), 32'd0);
    check("reset o_dbg_ack", 32'(o_dbg_ack), 32'd0);
    check("reset o_mem_en", 32'(o_mem_en), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    foreach (vq[i]) run(vq[i]);

    // Simultaneous pipeline and debug requests: pipeline wins, debug follows.
    @(posedge i_clk);
    @(negedge i_clk);
    drive_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    i_dbg_req  = 1'b1;
    i_dbg_addr = 10'd4;
    lat = 0; early = 1'b0; rd = '0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge i_clk);
      #1;
      if (o_dbg_ack) early = 1'b1;
      if (o_done) begin
        lat = n;
        rd  = o_rdata;
      end
    end
    i_req = 1'b0;
    check("arb pipe latency", 32'(lat), 32'd3);
    check("arb pipe rdata", rd, 32'h1122AB44);
    check("arb debug not first", 32'(early), 32'd0);
    dl = 0; drd = '0;
    for (int n = 1; n <= 10 && dl == 0; n++) begin
      @(posedge i_clk);
      #1;
      if (o_dbg_ack) begin
        dl  = n;
        drd = o_dbg_rdata;
      end
    end
    i_dbg_req = 1'b0;
    check("arb debug ack delay", 32'(dl), 32'd4);
    check("arb debug rdata", drd, 32'h1122AB44);

    // Reset asserted in WAIT of a byte store; the held request is re-sampled afterwards.
    @(posedge i_clk);
    @(negedge i_clk);
    w0 = nwr;
    drive_req(1'b1, 3'b000, 32'h21, 32'h00000099, 1'b0);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("rst mem_en", 32'(o_mem_en), 32'd0);
    check("rst mem_we", 32'(o_mem_we), 32'd0);
    check("rst o_done", 32'(o_done), 32'd0);
    check("rst o_rdata", o_rdata, 32'd0);
    check("rst o_misaligned", 32'(o_misaligned), 32'd0);
    check("rst o_dbg_ack", 32'(o_dbg_ack), 32'd0);
    check("rst o_dbg_rdata", o_dbg_rdata, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    check("rst no write", 32'(nwr - w0), 32'd0);
    check("rst ram unchanged", ram[8], 32'h7766BEEF);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge i_clk);
      #1;
      if (o_done) lat = n;
    end
    i_req = 1'b0;
    check("resample latency", 32'(lat), 32'd4);
    check("resample writes", 32'(nwr - w0), 32'd1);
    check("resample ram word", ram[8], 32'h776699EF);

    repeat (2) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access sequencer between the MEM pipeline stage and a single-port, synchronous-read 32-bit word RAM.
- Performs byte/half/word loads with lane extraction and sign extension.
- Performs byte/half stores as read-modify-write and word stores as a direct write.
- Arbitrates the RAM between the pipeline and the debug unit, which issues word reads only.

Parameters:
ADDR_W, 10, RAM word-address width (RAM depth 2^ADDR_W words)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_req  in  1  pipeline access request; held high until o_done
i_we  in  1  1=store, 0=load; sampled with i_req
i_type  in  3  000=byte, 001=half, 011=word; other codes illegal
i_addr  in  32  byte address; word index = i_addr[ADDR_W+1:2]
i_wdata  in  32  store data, right-aligned
o_rdata  out  32  load result; valid while o_done=1
o_done  out  1  one-cycle completion pulse
o_misaligned  out  1  pulses together with o_done on an illegal access
o_stall  out  1  combinational: i_req & (state != DONE)
i_dbg_req  in  1  debug word-read request; held until o_dbg_ack
i_dbg_addr  in  ADDR_W  debug word address
o_dbg_ack  out  1  one-cycle pulse; o_dbg_rdata valid in the same cycle
o_dbg_rdata  out  32  debug read data
o_mem_en  out  1  RAM enable
o_mem_we  out  1  RAM write enable
o_mem_addr  out  ADDR_W  RAM word address
o_mem_wdata  out  32  RAM write data
i_mem_rdata  in  32  RAM read data; valid one cycle after o_mem_en with o_mem_we=0

Behaviour:
- States: IDLE, RD, WAIT, WR, DONE, DRD, DWAIT, DACK.
- RAM outputs are decoded from state and captured registers only.
  - o_mem_en=1 only in RD, WR and DRD; o_mem_we=1 only in WR.
  - o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata are 0 in every other state.
- IDLE, i_req=1: capture we, type, addr and wdata; the pipeline has priority over debug.
  - Illegal type, half with addr[0]=1, or word with addr[1:0]!=0 → DONE with o_misaligned=1 and o_rdata=0. No RAM access.
  - Word store → WR.
  - All other accesses → RD.
- IDLE, i_req=0, i_dbg_req=1: capture i_dbg_addr → DRD.
- RD → WAIT (read issued).
- WAIT: sample i_mem_rdata.
  - Load: register the extracted, sign-extended value into o_rdata → DONE.
  - Sub-word store: register the merged word → WR.
- Lane rules (little-endian):
  - Byte: lane addr[1:0], lane 0 = bits [7:0].
  - Half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
  - Stores replace only the selected lane with i_wdata[7:0] or [15:0]; all other bits are preserved from the read.
- WR: write (merged word, or i_wdata for a word store) → DONE.
- DONE: o_done=1 for one cycle → IDLE. o_rdata holds until the next load completes.
- DRD → DWAIT → DACK. In DACK, o_dbg_rdata=i_mem_rdata (registered) and o_dbg_ack=1 → IDLE.
- A pending request is sampled again only in IDLE. A request that arrives during another access waits, with no loss.
- Latency from the capture cycle T, with o_done at:
  - Misaligned: T+1.
  - Word store: T+2.
  - Load: T+3.
  - Sub-word store: T+4.
  - Debug read: o_dbg_ack at T+3.
- Reset (any state, any time):
  - State goes to IDLE immediately.
  - All registered outputs (o_rdata, o_done, o_misaligned, o_dbg_ack, o_dbg_rdata) are cleared to 0.
  - RAM control drops to 0 in the same instant, so no partial write completes after reset asserts.
  - After release, a request still held high is re-sampled in IDLE.

Optional Feature:
- Macro MEM_UNSIGNED_LOAD_EN.
- Defined: adds input port i_unsigned (1 bit), sampled with i_req. When 1, byte and half loads are zero-extended (LBU/LHU). It has no effect on word loads or on stores.
- Undefined: the port is absent and all sub-word loads are sign-extended.

Test Plan:
- RAM[4]=0x11223344; store byte, addr 0x11, data 0x000000AB → exactly one read then one write of 0x1122AB44 to word 4; o_done at T+4.
- RAM[4]=0x1122AB44; load byte addr 0x11 → o_rdata 0xFFFFFFAB at T+3. Load half addr 0x12 → 0x00001122. With MEM_UNSIGNED_LOAD_EN and i_unsigned=1, load byte addr 0x11 → 0x000000AB.
- Store word, addr 0x20, data 0xDEADBEEF → single write to word 8, no read cycle; o_done at T+2.
- Load word addr 0x22, and separately type 010 → o_misaligned=1 with o_done at T+1; o_mem_en stays 0.
- i_req (load addr 0x10) and i_dbg_req (addr 4) rise in the same cycle → pipeline o_done first. The debug read is then captured in the following IDLE and o_dbg_ack follows 3 cycles later with 0x1122AB44.
- i_reset_n driven low during WAIT of a sub-word store → o_mem_en/o_mem_we immediately 0, no write occurs, RAM word unchanged, all outputs 0.
